// File: rtl/mult_booth_r4.sv
// -----------------------------------------------------------------------------
// mult_booth_r4
// Signed 32x32 radix-4 Booth multiplier. It runs 16 iterations and returns the
// low 32 bits of the product plus a signed-32 overflow flag.
//
// Ports:
//   clk       in   1   rising-edge clock
//   clr_n     in   1   asynchronous active-low reset
//   start     in   1   begin a multiply (honoured in IDLE or DONE only)
//   a         in  32   multiplicand, signed, sampled on the start edge
//   b         in  32   multiplier, signed, sampled on the start edge
//   result    out 32   product[31:0], registered, held until next completion
//   overflow  out  1   product does not fit in signed 32 bits, registered
//   ready     out  1   one-cycle pulse: result/overflow valid
//   busy      out  1   high while iterating
//
// Optional build macro:
//   MULT_EARLY_ZERO_EN - a zero operand sampled in IDLE skips straight to DONE
//                        with result=0 and overflow=0.
// -----------------------------------------------------------------------------
module mult_booth_r4 (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          load_s;
    logic          early_zero_s;
    logic          cnt_en_s;
    logic          finish_s;
    logic [33:0]   m_r;
    logic [64:0]   p_r;
    logic [3:0]    cnt_r;
    logic [33:0]   sum_s;
    logic [64:0]   p_step_s;
    logic [31:0]   result_r;
    logic          overflow_r;
    logic          ready_r;
    logic          busy_r;

    // Booth digit selection: multiple of M chosen by the overlapping triplet.
    function automatic logic [33:0] booth_addend(input logic [2:0] trip, input logic [33:0] m);
        logic [33:0] m2;
        m2 = {m[32:0], 1'b0};
        case (trip)
            3'b001, 3'b010: booth_addend = m;
            3'b011:         booth_addend = m2;
            3'b100:         booth_addend = ~m2 + 34'd1;
            3'b101, 3'b110: booth_addend = ~m + 34'd1;
            default:        booth_addend = 34'd0;
        endcase
    endfunction

    // Overflow: the upper 33 bits of the 64-bit product must be pure sign.
    function automatic logic prod_overflow(input logic [64:0] p);
        prod_overflow = ~((&p[64:32]) | ~(|p[64:32]));
    endfunction

`ifdef MULT_EARLY_ZERO_EN
    assign early_zero_s = (a == 32'd0) || (b == 32'd0);
`else
    assign early_zero_s = 1'b0;
`endif

    assign cnt_en_s = (state_r == RUN);
    assign finish_s = cnt_en_s && (cnt_r == 4'd15);

    // One Booth iteration: add digit*M into the high half, then shift by two.
    always_comb begin
        sum_s    = {{2{p_r[64]}}, p_r[64:33]} + booth_addend(p_r[2:0], m_r);
        p_step_s = {sum_s, p_r[32:2]};
    end

    // Next-state and load decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                    if (early_zero_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == 4'd15) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                // The zero shortcut is not taken here so that ready can never
                // pulse in two consecutive cycles.
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and the status outputs derived from the next state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            ready_r <= (state_nxt_s == DONE);
        end
    end

    // Operand load, iteration datapath and step counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_r   <= 34'd0;
            p_r   <= 65'd0;
            cnt_r <= 4'd0;
        end else if (load_s) begin
            m_r   <= {{2{a[31]}}, a};
            p_r   <= {32'd0, b, 1'b0};
            cnt_r <= 4'd0;
        end else if (cnt_en_s) begin
            p_r   <= p_step_s;
            cnt_r <= cnt_r + 4'd1;
        end else begin
            p_r   <= p_r;
            cnt_r <= cnt_r;
        end
    end

    // Result capture: taken from the final iteration, or zero on the shortcut.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            result_r   <= 32'd0;
            overflow_r <= 1'b0;
        end else if (finish_s) begin
            result_r   <= p_step_s[32:1];
            overflow_r <= prod_overflow(p_step_s);
        end else if (load_s && (state_nxt_s == DONE)) begin
            result_r   <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            result_r   <= result_r;
            overflow_r <= overflow_r;
        end
    end

    assign result   = result_r;
    assign overflow = overflow_r;
    assign ready    = ready_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_mult_booth_r4.sv
module tb_mult_booth_r4;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        overflow;
    logic        ready;
    logic        busy;

    int n_pass;
    int n_total;

    mult_booth_r4 dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .result   (result),
        .overflow (overflow),
        .ready    (ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for ready, counting cycles and busy samples.
    // Called right after the start edge (+1).
    task automatic wait_ready(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!ready && lat < 40) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full directed multiply: launch, wait, check latency/busy/result/pulse.
    task automatic run_mult(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] er, input logic eo,
                            input int elat, input int ebusy);
        int lat;
        int bc;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(lat, bc);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, bc, ebusy);
        check({tag, "_res"}, result, er);
        check({tag, "_ovf"}, overflow, eo);
        @(posedge clk); #1;
        check({tag, "_pulse"}, ready, 1'b0);
    endtask

    int lat;
    int bc;
    int zlat;
    int zbusy;
    int seen_ready;

    initial begin
        n_pass  = 0;
        n_total = 0;
        clr_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res",   result,   32'd0);
        check("rst_ovf",   overflow, 1'b0);
        check("rst_ready", ready,    1'b0);
        check("rst_busy",  busy,     1'b0);
        @(negedge clk);
        clr_n = 1'b1;

        run_mult("3x5",      32'd3,          32'd5,          32'h0000000F, 1'b0, 16, 16);
        run_mult("m7x6",     32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0, 16, 16);
        run_mult("maxx2",    32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1, 16, 16);
        run_mult("minxm1",   32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1, 16, 16);
        run_mult("negfit",   32'hFFFF8000,   32'h00010000,   32'h80000000, 1'b0, 16, 16);
        run_mult("posedge2", 32'h00010000,   32'h00008000,   32'h80000000, 1'b1, 16, 16);
        run_mult("big",      32'h00012345,   32'h00010000,   32'h23450000, 1'b1, 16, 16);

        // Start re-pulsed during RUN is ignored; then start held in DONE.
        @(negedge clk);
        a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end   // now after E4
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;               // E5 samples start in RUN
        start = 1'b0;
        check("ign_busy", busy, 1'b1);
        lat = 5; seen_ready = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_lat", lat, 16);
        check("ign_res", result, 32'd15);
        // hold start through DONE with new operands
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;               // restart edge
        start = 1'b0;
        check("b2b_noready", ready, 1'b0);
        check("b2b_hold", result, 32'd15);
        wait_ready(lat, bc);
        check("b2b_lat", lat, 16);
        check("b2b_res", result, 32'd81);

        // Reset mid-operation.
        @(negedge clk);
        a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end   // after E7
        @(posedge clk);                               // E8
        #2;
        clr_n = 1'b0;
        #1;
        check("mid_res",   result,   32'd0);
        check("mid_busy",  busy,     1'b0);
        check("mid_ready", ready,    1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        seen_ready = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ready) seen_ready++;
        end
        check("mid_noready", seen_ready, 0);
        run_mult("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 16, 16);

`ifdef MULT_EARLY_ZERO_EN
        zlat = 0; zbusy = 0;
`else
        zlat = 16; zbusy = 16;
`endif
        run_mult("zero", 32'd0, 32'h12345678, 32'd0, 1'b0, zlat, zbusy);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
